key_entry_frontend: RTL and testbench

Synchronous front end that conditions the raw player buttons (four symbol keys plus enter) for the guess-number game core. It synchronizes and debounces each input and turns each clean press into a single coded event on a valid/ready interface. It rejects simultaneous or overlapping presses. It sits directly upstream of the sequence-entry/compare logic, which consumes one event per handshake instead of raw button edges.

---
 rtl/guess_pkg.sv | 34 +++
 rtl/key_debounce.sv | 54 +++++
 rtl/key_entry_frontend.sv | 83 ++++++++
 tb/tb_key_entry_frontend.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/guess_pkg.sv
// Event codes and helpers shared by the key entry front end and the
// downstream sequence-entry/compare logic of the guess-number game.
package guess_pkg;

  typedef logic [2:0] evt_code_t;

  localparam evt_code_t EVT_KEY1  = 3'd0;
  localparam evt_code_t EVT_KEY2  = 3'd1;
  localparam evt_code_t EVT_KEY3  = 3'd2;
  localparam evt_code_t EVT_KEY4  = 3'd3;
  localparam evt_code_t EVT_ENTER = 3'd4;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int NUM_CHANNELS            = 5;

  // Channel order is key 1..4 then enter; callers guarantee a one-hot input.
  function automatic evt_code_t channel_to_code(input logic [4:0] onehot);
    evt_code_t code;
    case (onehot)
      5'b00001: code = EVT_KEY1;
      5'b00010: code = EVT_KEY2;
      5'b00100: code = EVT_KEY3;
      5'b01000: code = EVT_KEY4;
      5'b10000: code = EVT_ENTER;
      default:  code = EVT_KEY1;
    endcase
    return code;
  endfunction

  function automatic logic is_onehot(input logic [4:0] vec);
    return (vec != 5'd0) && ((vec & (vec - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One button channel: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse marking the debounced press.
module key_debounce
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sync_q1;
  logic sync_q2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive differing samples; the level flips on the last one.
  // rise is raised on the same edge as stable so arbitration sees both together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else if (sync_q2 == stable) begin
      cnt  <= '0;
      rise <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      stable <= ~stable;
      rise   <= ~stable;
    end else begin
      cnt  <= cnt + CNT_ONE;
      rise <= 1'b0;
    end
  end

endmodule

// File: rtl/key_entry_frontend.sv
// Debounces four symbol keys plus enter and turns each clean, isolated
// press into one coded event on a valid/ready interface.
module key_entry_frontend
  import guess_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  input  logic       enter_in,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready,
  output logic       conflict,
  output logic       overrun
);

  logic [NUM_CHANNELS-1:0] raw_bus;
  logic [NUM_CHANNELS-1:0] stable_bus;
  logic [NUM_CHANNELS-1:0] rise_bus;
  logic                    accept;
  logic                    reject;
  evt_code_t               new_code;

  assign raw_bus = {enter_in, key_in};

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_bus[g]),
      .stable(stable_bus[g]),
      .rise  (rise_bus[g])
    );
  end

  // A press wins only if it is alone and no other channel is still held.
  always_comb begin
    accept   = 1'b0;
    reject   = 1'b0;
    new_code = channel_to_code(rise_bus);
    if (rise_bus != 5'd0) begin
      if (is_onehot(rise_bus) && ((stable_bus & ~rise_bus) == 5'd0)) begin
        accept = 1'b1;
      end else begin
        reject = 1'b1;
      end
    end else begin
      accept = 1'b0;
      reject = 1'b0;
    end
  end

  // Output register: a held event is never overwritten; a lost press sets overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_code  <= EVT_KEY1;
      conflict  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      conflict <= reject;
      if (accept) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_code  <= new_code;
        end else begin
          overrun <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end else begin
        evt_valid <= evt_valid;
      end
    end
  end

endmodule

// File: tb/tb_key_entry_frontend.sv
// Self-checking bench for key_entry_frontend with a short debounce window:
// table-driven single presses plus hand-written multi-cycle corner cases.
module tb_key_entry_frontend;

  localparam int DEB     = 4;
  localparam int LATENCY = DEB + 3;

  logic       clk;
  logic       reset;
  logic [3:0] key_in;
  logic       enter_in;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;
  logic       conflict;
  logic       overrun;

  key_entry_frontend #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_in   (key_in),
    .enter_in (enter_in),
    .evt_valid(evt_valid),
    .evt_code (evt_code),
    .evt_ready(evt_ready),
    .conflict (conflict),
    .overrun  (overrun)
  );

  typedef struct {
    logic [4:0] press;   // {enter, key4..key1}
    int         hold;
    int         exp_events;
    int         exp_conflicts;
    logic [2:0] code;
  } vec_t;

  vec_t     vecs [10];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       cyc      = 0;
  int       ev_count = 0;
  int       conf_count = 0;
  int       rise_cyc = -100;
  logic     prev_valid = 1'b0;
  logic     prev_conf  = 1'b0;
  int       exp_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: handshakes are compared against the scoreboard queue.
  always @(negedge clk) begin
    if (evt_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = evt_valid;
    if (conflict) begin
      conf_count++;
      check("conflict_width", int'(prev_conf), 0);
    end
    prev_conf = conflict;
    if (evt_valid && evt_ready) begin
      ev_count++;
      if (exp_q.size() == 0) check("unexpected_event", int'(evt_code), -1);
      else check("evt_code", int'(evt_code), exp_q.pop_front());
    end
  end

  task automatic drive(input logic [4:0] p);
    {enter_in, key_in} = p;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ev0, cf0, t0;
    ev0 = ev_count;
    cf0 = conf_count;
    @(posedge clk); #1;
    t0 = cyc;
    drive(v.press);
    if (v.exp_events != 0) exp_q.push_back(int'(v.code));
    repeat (v.hold) @(posedge clk);
    #1 drive(5'd0);
    repeat (20) @(posedge clk);
    #1;
    check($sformatf("vec%0d_events", idx), ev_count - ev0, v.exp_events);
    check($sformatf("vec%0d_conflicts", idx), conf_count - cf0, v.exp_conflicts);
    if (v.exp_events != 0) check($sformatf("vec%0d_latency", idx), rise_cyc - t0, LATENCY);
  endtask

  initial begin
    int ev0, cf0, t0;
    vecs[0] = '{5'b00100, 10, 1, 0, 3'd2};  // clean press key 3
    vecs[1] = '{5'b10000, 10, 1, 0, 3'd4};  // enter
    vecs[2] = '{5'b01001, 10, 0, 1, 3'd0};  // keys 1 and 4 together
    vecs[3] = '{5'b00010,  3, 0, 0, 3'd0};  // one sample short of debounce
    vecs[4] = '{5'b00010,  4, 1, 0, 3'd1};  // exactly long enough
    vecs[5] = '{5'b00001, 10, 1, 0, 3'd0};  // full entry sequence 1,2,3,4,enter
    vecs[6] = '{5'b00010, 10, 1, 0, 3'd1};
    vecs[7] = '{5'b00100, 10, 1, 0, 3'd2};
    vecs[8] = '{5'b01000, 10, 1, 0, 3'd3};
    vecs[9] = '{5'b10000, 10, 1, 0, 3'd4};

    reset = 1'b1;
    evt_ready = 1'b1;
    drive(5'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", int'(evt_valid), 0);
    check("reset_code", int'(evt_code), 0);
    check("reset_conflict", int'(conflict), 0);
    check("reset_overrun", int'(overrun), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
    check("no_overrun_after_table", int'(overrun), 0);

    // Bouncing enter: short pulses, then a real hold.
    ev0 = ev_count; cf0 = conf_count;
    for (int w = 1; w <= 3; w++) begin
      @(posedge clk); #1 drive(5'b10000);
      repeat (w) @(posedge clk);
      #1 drive(5'd0);
      repeat (2) @(posedge clk);
    end
    @(posedge clk); #1;
    t0 = cyc;
    drive(5'b10000);
    exp_q.push_back(4);
    repeat (10) @(posedge clk);
    #1 drive(5'd0);
    repeat (20) @(posedge clk);
    #1;
    check("bounce_events", ev_count - ev0, 1);
    check("bounce_latency", rise_cyc - t0, LATENCY);
    check("bounce_conflicts", conf_count - cf0, 0);

    // Key 2 held, then key 1 added: only the second press is rejected.
    ev0 = ev_count; cf0 = conf_count;
    @(posedge clk); #1 drive(5'b00010);
    exp_q.push_back(1);
    repeat (10) @(posedge clk);
    #1 drive(5'b00011);
    repeat (10) @(posedge clk);
    #1 drive(5'd0);
    repeat (20) @(posedge clk);
    #1;
    check("held_events", ev_count - ev0, 1);
    check("held_conflicts", conf_count - cf0, 1);

    // Backpressure: first press is held, second is dropped.
    ev0 = ev_count;
    evt_ready = 1'b0;
    @(posedge clk); #1 drive(5'b00001);
    exp_q.push_back(0);
    repeat (10) @(posedge clk);
    #1 drive(5'd0);
    repeat (20) @(posedge clk);
    #1;
    check("bp_valid_held", int'(evt_valid), 1);
    check("bp_code_held", int'(evt_code), 0);
    check("bp_no_overrun_yet", int'(overrun), 0);
    drive(5'b00010);
    repeat (10) @(posedge clk);
    #1 drive(5'd0);
    repeat (20) @(posedge clk);
    #1;
    check("bp_valid_still", int'(evt_valid), 1);
    check("bp_code_still", int'(evt_code), 0);
    check("bp_overrun", int'(overrun), 1);
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("bp_events", ev_count - ev0, 1);
    check("bp_valid_cleared", int'(evt_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);

    // Reset mid-debounce, then while an event is pending, key 3 held throughout.
    evt_ready = 1'b0;
    @(posedge clk); #1 drive(5'b00100);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rst1_valid", int'(evt_valid), 0);
    check("rst1_overrun", int'(overrun), 0);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("rst_pending_valid", int'(evt_valid), 1);
    check("rst_pending_code", int'(evt_code), 2);
    #1 reset = 1'b1;
    #1;
    check("rst2_valid", int'(evt_valid), 0);
    check("rst2_code", int'(evt_code), 0);
    check("rst2_conflict", int'(conflict), 0);
    check("rst2_overrun", int'(overrun), 0);
    ev0 = ev_count;
    evt_ready = 1'b1;
    exp_q.push_back(2);
    t0 = cyc;
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 drive(5'd0);
    repeat (20) @(posedge clk);
    #1;
    check("rst_re_events", ev_count - ev0, 1);
    check("rst_re_latency", rise_cyc - t0, LATENCY);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
